spi_slave_rx: RTL

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_slave_rx_pkg.sv | 19 +
 rtl/spi_sync_2ff.sv | 22 ++
 rtl/spi_slave_rx.sv | 126 ++++++++++++
 3 files changed

// File: rtl/spi_slave_rx_pkg.sv
// spi_slave_rx_pkg: shared SPI mode constants, SCK edge code and counter width helper
package spi_slave_rx_pkg;

    localparam logic CPOL_IDLE_LOW     = 1'b0;
    localparam logic CPOL_IDLE_HIGH    = 1'b1;
    localparam logic CPHA_LEAD_SAMPLE  = 1'b0;
    localparam logic CPHA_TRAIL_SAMPLE = 1'b1;

    typedef enum logic [1:0] {
        EDGE_NONE  = 2'd0,
        EDGE_LEAD  = 2'd1,
        EDGE_TRAIL = 2'd2
    } sck_edge_t;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/spi_sync_2ff.sv
// spi_sync_2ff: two-flop synchronizer bringing one SPI pin into the i_sys_clk domain
module spi_sync_2ff (
    input  logic i_sys_clk,
    input  logic i_reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // shift the asynchronous pin through two flops
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampling SPI slave (RX word + TX buffer); SPI_SLAVE_FRAME_ERR_EN adds frame_err
module spi_slave_rx
    import spi_slave_rx_pkg::*;
#(
    parameter int   DATA_WIDTH = 8,
    parameter logic CPOL       = CPOL_IDLE_LOW,
    parameter logic CPHA       = CPHA_LEAD_SAMPLE
) (
    input  logic                  i_sys_clk,
    input  logic                  i_reset_n,
    input  logic                  SCK,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
`ifdef SPI_SLAVE_FRAME_ERR_EN
    output logic                  frame_err,
`endif
    output logic                  spi_busy
);

    localparam int              CW          = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0]   LAST        = CW'(DATA_WIDTH - 1);
    localparam sck_edge_t       SAMPLE_EDGE = (CPHA == CPHA_TRAIL_SAMPLE) ? EDGE_TRAIL : EDGE_LEAD;
    localparam sck_edge_t       SHIFT_EDGE  = (CPHA == CPHA_TRAIL_SAMPLE) ? EDGE_LEAD : EDGE_TRAIL;

    logic                  sck_s, cs_s, mosi_s;
    logic                  sck_d, cs_d;
    logic                  cs_fall, cs_rise, sample, shift, wrap, xfer;
    sck_edge_t             sck_edge;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-2:0] rx_shift;
    logic [DATA_WIDTH-1:0] rx_next, tx_shift, tx_buf, next_word;
    logic                  tx_full;

    spi_sync_2ff u_sync_sck  (.i_sys_clk(i_sys_clk), .i_reset_n(i_reset_n), .d(SCK),  .q(sck_s));
    spi_sync_2ff u_sync_cs   (.i_sys_clk(i_sys_clk), .i_reset_n(i_reset_n), .d(CS),   .q(cs_s));
    spi_sync_2ff u_sync_mosi (.i_sys_clk(i_sys_clk), .i_reset_n(i_reset_n), .d(MOSI), .q(mosi_s));

    assign cs_fall   = cs_d & ~cs_s;
    assign cs_rise   = ~cs_d & cs_s;
    assign sck_edge  = (sck_s == sck_d) ? EDGE_NONE : (sck_s != CPOL) ? EDGE_LEAD : EDGE_TRAIL;
    assign sample    = spi_busy & ~cs_rise & (sck_edge == SAMPLE_EDGE);
    assign shift     = spi_busy & ~cs_rise & (sck_edge == SHIFT_EDGE);
    assign wrap      = sample & (bit_cnt == LAST);
    assign xfer      = cs_fall | wrap;
    assign next_word = tx_full ? tx_buf : '0;
    assign rx_next   = {rx_shift, mosi_s};
    assign tx_ready  = ~tx_full;

    // previous synchronized SCK/CS levels for edge detection
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sck_d <= 1'b0;
            cs_d  <= 1'b0;
        end else begin
            sck_d <= sck_s;
            cs_d  <= cs_s;
        end
    end

    // TX buffer: a word transfer wins over a same-cycle tx_load
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tx_buf  <= '0;
            tx_full <= 1'b0;
        end else if (xfer) begin
            tx_buf  <= '0;
            tx_full <= 1'b0;
        end else if (tx_load && !tx_full) begin
            tx_buf  <= tx_data;
            tx_full <= 1'b1;
        end
    end

    // frame control, RX sampling and MISO shifting; tx_shift holds bits not yet on MISO
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            spi_busy <= 1'b0;
            bit_cnt  <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_shift <= '0;
            MISO     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (cs_fall) begin
                spi_busy <= 1'b1;
                bit_cnt  <= '0;
                rx_shift <= '0;
                tx_shift <= (CPHA == CPHA_TRAIL_SAMPLE) ? next_word : next_word << 1;
                MISO     <= (CPHA == CPHA_TRAIL_SAMPLE) ? 1'b0 : next_word[DATA_WIDTH-1];
            end else if (cs_rise) begin
                spi_busy <= 1'b0;
                bit_cnt  <= '0;
                rx_shift <= '0;
                MISO     <= 1'b0;
            end else if (sample) begin
                rx_shift <= rx_next[DATA_WIDTH-2:0];
                bit_cnt  <= wrap ? '0 : bit_cnt + 1'b1;
                if (wrap) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                    tx_shift <= next_word;
                end
            end else if (shift) begin
                MISO     <= tx_shift[DATA_WIDTH-1];
                tx_shift <= tx_shift << 1;
            end
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    // flag a CS rise that cuts a word short
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) frame_err <= 1'b0;
        else            frame_err <= cs_rise & (bit_cnt != '0);
    end
`endif

endmodule
